// File: rtl/dram_bank_responder_pkg.sv
// Shared definitions for the row-granular DRAM responder.
// Holds the bank geometry, the precharge/activate timing, the derived field
// widths, the row/address types and the controller state encoding.
package dram_bank_responder_pkg;

  localparam int ROW_WIDTH              = 512;
  localparam int NUM_BANKS              = 1;
  localparam int NUM_ROWS               = 100;
  localparam int ADDRESS_LEN            = 10;
  localparam int PRECHARGE_CYCLES       = 10;
  localparam int BANK_ACTIVATION_CYCLES = 21;

  // Flat row space covered by the storage array.
  localparam int TOTAL_ROWS = NUM_BANKS * NUM_ROWS;
  localparam int ARRAY_AW   = (TOTAL_ROWS > 1) ? $clog2(TOTAL_ROWS) : 1;

  // Bank index and in-bank row index widths; never allowed to collapse to 0.
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ROW_AW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  // The timing counter only has to hold the longer of the two waits.
  localparam int MAX_WAIT = (PRECHARGE_CYCLES > BANK_ACTIVATION_CYCLES) ?
                            PRECHARGE_CYCLES : BANK_ACTIVATION_CYCLES;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  typedef logic [ROW_WIDTH-1:0]   dram_row_t;
  typedef logic [ADDRESS_LEN-1:0] dram_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    ACTIVATE,
    ACCESS,
    RESP
  } dram_state_e;

  // True when a flat address names a row that physically exists.
  function automatic logic addr_in_range(input dram_addr_t addr);
    return int'(addr) < TOTAL_ROWS;
  endfunction

endpackage

// File: rtl/dram_row_array.sv
// Row storage for every bank, addressed by flat row number.
// One synchronous write port and one registered read port sharing an address.
// Contents are deliberately not reset so rows survive a controller reset.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write wdata into row addr at the clock edge
//   re     in   capture row addr into rdata at the clock edge
//   addr   in   flat row address
//   wdata  in   row write data
//   rdata  out  registered row read data, holds until the next re
module dram_row_array
  import dram_bank_responder_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [ARRAY_AW-1:0] addr,
  input  dram_row_t           wdata,
  output dram_row_t           rdata
);

  dram_row_t mem [TOTAL_ROWS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dram_bank_responder.sv
// Memory-side responder of the row-granular DRAM request interface.
// Accepts one read or write at a time, models per-bank open-row state with
// precharge and activation delays, and returns a whole row per response.
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   req_valid/req_ready          request handshake (ready only while idle)
//   req_we, req_addr, req_wdata  request direction, flat row address, write row
//   resp_valid/resp_ready        response handshake, held until accepted
//   resp_rdata                   read row (zero for writes and errors)
//   resp_err                     address beyond the last row
//   hit_count                    saturating count of row-buffer hits
module dram_bank_responder
  import dram_bank_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  dram_addr_t  req_addr,
  input  dram_row_t   req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output dram_row_t   resp_rdata,
  output logic        resp_err,
  output logic [31:0] hit_count
);

  dram_state_e         state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                we_reg;
  logic                err_reg;
  logic [ARRAY_AW-1:0] addr_reg;
  logic [BANK_W-1:0]   bank_reg;
  logic [ROW_AW-1:0]   row_reg;
  dram_row_t           wdata_reg;
  logic [31:0]         hit_count_reg;

  logic                accept;
  logic                hit_inc;
  logic                mem_we;
  logic                mem_re;
  dram_row_t           mem_rdata;

  // Request decode, evaluated on the incoming address while idle.
  logic [31:0]         addr_ext;
  logic [BANK_W-1:0]   req_bank;
  logic [ROW_AW-1:0]   req_row;
  logic                req_err;
  logic [NUM_BANKS-1:0] bank_hit;
  logic [NUM_BANKS-1:0] bank_open;
  logic                req_hit;
  logic                req_open;

  assign addr_ext = 32'(req_addr);
  assign req_bank = BANK_W'(addr_ext / 32'(NUM_ROWS));
  assign req_row  = ROW_AW'(addr_ext % 32'(NUM_ROWS));
  assign req_err  = !addr_in_range(req_addr);
  assign req_hit  = |bank_hit;
  assign req_open = |bank_open;

  // Per-bank open-row register. A bank closes when its precharge finishes
  // and opens on the latched row when its activation finishes.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : bank_g
      logic              open_valid_reg;
      logic [ROW_AW-1:0] open_row_reg;
      logic              targeted;

      assign targeted = (bank_reg == BANK_W'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          open_valid_reg <= 1'b0;
          open_row_reg   <= '0;
        end else if (targeted) begin
          if (state_reg == PRECHARGE && cnt_reg == '0) begin
            open_valid_reg <= 1'b0;
          end else if (state_reg == ACTIVATE && cnt_reg == '0) begin
            open_valid_reg <= 1'b1;
            open_row_reg   <= row_reg;
          end
        end
      end

      // Gated by !req_err so a truncated out-of-range bank index never matches.
      assign bank_open[gi] = !req_err && open_valid_reg && (req_bank == BANK_W'(gi));
      assign bank_hit[gi]  = bank_open[gi] && (open_row_reg == req_row);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    hit_inc    = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_err) begin
            state_next = RESP;
          end else if (req_hit) begin
            state_next = ACCESS;
            hit_inc    = 1'b1;
          end else if (!req_open) begin
            state_next = ACTIVATE;
            cnt_next   = CNT_W'(BANK_ACTIVATION_CYCLES - 1);
          end else begin
            state_next = PRECHARGE;
            cnt_next   = CNT_W'(PRECHARGE_CYCLES - 1);
          end
        end
      end
      PRECHARGE: begin
        if (cnt_reg == '0) begin
          state_next = ACTIVATE;
          cnt_next   = CNT_W'(BANK_ACTIVATION_CYCLES - 1);
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ACTIVATE: begin
        if (cnt_reg == '0) begin
          state_next = ACCESS;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ACCESS: begin
        mem_we     = we_reg;
        mem_re     = !we_reg;
        state_next = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      err_reg       <= 1'b0;
      addr_reg      <= '0;
      bank_reg      <= '0;
      row_reg       <= '0;
      wdata_reg     <= '0;
      hit_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg    <= req_we;
        err_reg   <= req_err;
        addr_reg  <= ARRAY_AW'(req_addr);
        bank_reg  <= req_bank;
        row_reg   <= req_row;
        wdata_reg <= req_wdata;
      end
      if (hit_inc && hit_count_reg != 32'hFFFF_FFFF) begin
        hit_count_reg <= hit_count_reg + 32'd1;
      end
    end
  end

  dram_row_array u_row_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_reg),
    .wdata (wdata_reg),
    .rdata (mem_rdata)
  );

  // The array output only changes on a read in ACCESS, so it stays stable
  // for the whole response; writes and errors report a zero row.
  assign req_ready  = (state_reg == IDLE) && !rst;
  assign resp_valid = (state_reg == RESP);
  assign resp_err   = (state_reg == RESP) && err_reg;
  assign resp_rdata = (state_reg == RESP && !err_reg && !we_reg) ? mem_rdata : '0;
  assign hit_count  = hit_count_reg;

endmodule
